mdio_master: RTL and testbench
==============================

// Module: mdio_master
// PURPOSE
//  Clause-22 MDIO management master that drives eth_mdc/eth_mdio toward the Ethernet PHY.
//  Executes one read or write frame per op_exec pulse and returns read data plus a PHY-ack flag.
//  Sits between the register read/write test controller (key/LED logic) and the PHY pins.
//  Pin-level tri-state is inside the block; eth_mdio is a top-level inout.
// PARAMETERS
//  CLOCK_FREQ  50_000_000  sys_clk frequency, Hz
//  MDC_FREQ    1_000_000   eth_mdc frequency, Hz; HALF = CLOCK_FREQ/(2*MDC_FREQ) must be >= 2 (elaboration check)
// PORTS
//  sys_clk      in     1   system clock; all logic on posedge
//  sys_rst_n    in     1   asynchronous, active-low reset
//  op_exec      in     1   start pulse, 1 sys_clk wide; sampled only when busy=0
//  op_rh_wl     in     1   1 = read, 0 = write; captured with op_exec
//  op_phy_addr  in     5   PHY address; captured with op_exec
//  op_reg_addr  in     5   register address; captured with op_exec
//  op_wr_data   in     16  write data; captured with op_exec
//  busy         out    1   high from the cycle after an accepted op_exec until op_done
//  op_done      out    1   1-cycle pulse at frame end
//  op_rd_data   out    16  read data; valid from op_done, held until the next read's op_done
//  op_rd_ack    out    1   1 = PHY drove TA bit 2 low on the last read; updated at op_done
//  eth_mdc      out    1   management clock
//  eth_mdio     inout  1   management data; driven while oe=1, else 1'bz
// BEHAVIOUR
//  Reset values: busy=0, op_done=0, op_rd_data=16'h0000, op_rd_ack=0, eth_mdc=0, mdio oe=0 (released).
//  MDC: free-running divider. Counter 0..HALF-1; eth_mdc toggles at HALF-1. rise_tick/fall_tick = the cycle eth_mdc goes 0->1 / 1->0.
//  The master changes MDIO only on fall_tick. It samples MDIO on rise_tick, using a 2-flop synchronised copy of eth_mdio.
//  Frame: 64 bits, index 0..63, MSB first in every field.
//   0-31 preamble all 1; 32-33 ST=01; 34-35 OP (read 10, write 01); 36-40 PHYAD; 41-45 REGAD;
//   46-47 TA (write: drive 10; read: oe=0); 48-63 DATA (write: driven; read: oe=0, sampled).
//  FSM:
//   IDLE  : accept op_exec, latch the operands, set busy; -> WAIT.
//   WAIT  : on the next fall_tick drive bit 0; -> PRE.
//   PRE   : bits 0-31.
//   HEAD  : bits 32-45.
//   TA    : bits 46-47. On read, rise_tick of bit 47 latches ack_n = sampled value.
//   DATA  : bits 48-63. On read, each rise_tick shifts the sampled bit into the rd shift register.
//   END   : on the fall_tick after bit 63: oe=0, op_done=1 for 1 cycle, busy=0.
//           On read, op_rd_data <= shift register and op_rd_ack <= ~ack_n. -> IDLE.
//  Bit counter is 6 bits and advances on each fall_tick in PRE..DATA. It does not wrap mid-frame.
//  Latency: op_exec to op_done = (cycles to next fall_tick, <= 2*HALF) + 64*2*HALF sys_clk.
//  op_exec while busy=1: ignored; no queuing and no operand update.
//  op_exec in the same cycle as op_done: ignored (busy is still considered high).
//  Reset mid-frame: FSM -> IDLE, MDIO released immediately, no op_done. Idle line is pulled up externally.
//  Write ops leave op_rd_data and op_rd_ack unchanged.
//  No PHY present (line pulled up): read returns 16'hFFFF with op_rd_ack=0.
// STRUCTURE
//  Shared header mdio_defs.vh:
//   localparams MDIO_ST=2'b01, MDIO_OP_RD=2'b10, MDIO_OP_WR=2'b01, MDIO_TA_WR=2'b10
//   bit indices PRE_END=31, HEAD_END=45, TA_END=47, DATA_END=63
//   FSM state encodings
//  Sub-module mdc_clk_gen (CLOCK_FREQ, MDC_FREQ): outputs eth_mdc, rise_tick, fall_tick.
//  mdio_master holds the FSM, the 64-bit TX shift register, the RX shift register, the synchroniser and the tri-state buffer.
// TESTING
//  Bench: PHY BFM on eth_mdio with pull-up; CLOCK_FREQ=50M, MDC_FREQ=1M (HALF=25).
//  1 Divider: after reset, eth_mdc period = 50 sys_clk, high for 25.
//    MDIO must change only in fall_tick cycles.
//  2 Write: phy=5'h01, reg=5'h00, data=16'h1140.
//    BFM must capture 64'hFFFFFFFF_5082_1140. op_done must fire once; rd outputs unchanged.
//  3 Read with PHY: phy=5'h01, reg=5'h02.
//    BFM must see header bits 14'b01_10_00001_00010, then drives TA=0 and 16'h0141.
//    -> op_rd_data=16'h0141, op_rd_ack=1; oe=0 throughout bits 46-63.
//  4 Read, no PHY: phy=5'h1F -> op_rd_data=16'hFFFF, op_rd_ack=0.
//  5 Busy: second op_exec at bit 40 of a write (new data 16'hAAAA).
//    -> only one frame is sent, carrying the original data; busy stays high until that frame's op_done.
//  6 Reset at bit 50 of a read: eth_mdio goes Z the next cycle; op_done, busy, op_rd_data=0 and op_rd_ack=0 stay low.
//    A subsequent read completes normally.

Source files
------------

// File: rtl/mdio_master_pkg.sv
// Shared frame constants, FSM state encoding and frame builder for the MDIO master.
package mdio_master_pkg;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  localparam logic [5:0] PRE_END  = 6'd31;
  localparam logic [5:0] HEAD_END = 6'd45;
  localparam logic [5:0] TA_END   = 6'd47;
  localparam logic [5:0] DATA_END = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_PRE, ST_HEAD, ST_TA, ST_DATA, ST_END
  } mdio_state_e;

  // Read frames leave TA/DATA undriven, so their TX bits are don't-care ones.
  function automatic logic [63:0] build_frame(input logic rd, input logic [4:0] phy,
                                              input logic [4:0] regad, input logic [15:0] wdata);
    return {32'hFFFF_FFFF, MDIO_ST, rd ? MDIO_OP_RD : MDIO_OP_WR, phy, regad,
            rd ? 2'b11 : MDIO_TA_WR, rd ? 16'hFFFF : wdata};
  endfunction

  function automatic mdio_state_e phase_of(input logic [5:0] idx);
    if (idx > TA_END)        return ST_DATA;
    else if (idx > HEAD_END) return ST_TA;
    else if (idx > PRE_END)  return ST_HEAD;
    else                     return ST_PRE;
  endfunction

endpackage

// File: rtl/mdio_master_mdc_clk_gen.sv
// Free-running MDC divider; ticks flag the sys_clk edge on which eth_mdc rises or falls.
module mdc_clk_gen #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned MDC_FREQ   = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic eth_mdc,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int unsigned HALF = CLOCK_FREQ / (2 * MDC_FREQ);
  localparam int unsigned CW   = (HALF >= 2) ? $clog2(HALF) : 1;

  generate
    if (HALF < 2) begin : g_bad_half
      $error("mdc_clk_gen: CLOCK_FREQ/(2*MDC_FREQ) must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q;
  logic          mdc_q;
  logic          at_top;

  assign at_top = (cnt_q == CW'(HALF - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (at_top) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Ticks are high in the cycle whose closing edge flips eth_mdc.
  assign eth_mdc   = mdc_q;
  assign rise_tick = at_top & ~mdc_q;
  assign fall_tick = at_top & mdc_q;

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one 64-bit read or write frame per accepted op_exec.
module mdio_master
  import mdio_master_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned MDC_FREQ   = 1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        op_exec,
  input  logic        op_rh_wl,
  input  logic [4:0]  op_phy_addr,
  input  logic [4:0]  op_reg_addr,
  input  logic [15:0] op_wr_data,
  output logic        busy,
  output logic        op_done,
  output logic [15:0] op_rd_data,
  output logic        op_rd_ack,
  output logic        eth_mdc,
  inout  wire         eth_mdio
);

  logic rise_tick, fall_tick;

  mdc_clk_gen #(.CLOCK_FREQ(CLOCK_FREQ), .MDC_FREQ(MDC_FREQ)) u_mdc (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .eth_mdc   (eth_mdc),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  mdio_state_e  state_q;
  logic [63:0]  tx_q;
  logic [15:0]  rx_q;
  logic [5:0]   bit_cnt_q;
  logic [5:0]   bit_nxt;
  logic         rd_q, ack_n_q;
  logic         mdio_oe_q, mdio_out_q;
  logic         sync1_q, sync2_q;
  logic         busy_q, done_q, rd_ack_q;
  logic [15:0]  rd_data_q;

  assign bit_nxt = bit_cnt_q + 6'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= eth_mdio;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      rd_q       <= 1'b0;
      ack_n_q    <= 1'b1;
      mdio_oe_q  <= 1'b0;
      mdio_out_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_ack_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_exec) begin
            tx_q    <= build_frame(op_rh_wl, op_phy_addr, op_reg_addr, op_wr_data);
            rd_q    <= op_rh_wl;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (fall_tick) begin
            mdio_out_q <= tx_q[63];
            mdio_oe_q  <= 1'b1;
            tx_q       <= {tx_q[62:0], 1'b0};
            bit_cnt_q  <= '0;
            state_q    <= ST_PRE;
          end
        end
        ST_PRE, ST_HEAD, ST_TA, ST_DATA: begin
          if (rise_tick && rd_q) begin
            if (state_q == ST_TA && bit_cnt_q == TA_END) ack_n_q <= sync2_q;
            if (state_q == ST_DATA) rx_q <= {rx_q[14:0], sync2_q};
          end
          if (fall_tick) begin
            if (bit_cnt_q == DATA_END) begin
              mdio_oe_q <= 1'b0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              if (rd_q) begin
                rd_data_q <= rx_q;
                rd_ack_q  <= ~ack_n_q;
              end
              state_q <= ST_END;
            end else begin
              // Reads hand the line to the PHY from the first TA bit onward.
              bit_cnt_q  <= bit_nxt;
              mdio_out_q <= tx_q[63];
              mdio_oe_q  <= ~(rd_q && bit_nxt > HEAD_END);
              tx_q       <= {tx_q[62:0], 1'b0};
              state_q    <= phase_of(bit_nxt);
            end
          end
        end
        ST_END:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign eth_mdio   = mdio_oe_q ? mdio_out_q : 1'bz;
  assign busy       = busy_q;
  assign op_done    = done_q;
  assign op_rd_data = rd_data_q;
  assign op_rd_ack  = rd_ack_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master with a pulled-up MDIO line and a simple PHY model.
module tb_mdio_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        op_exec = 1'b0;
  logic        op_rh_wl = 1'b0;
  logic [4:0]  op_phy_addr = '0;
  logic [4:0]  op_reg_addr = '0;
  logic [15:0] op_wr_data = '0;
  logic        busy, op_done, op_rd_ack, eth_mdc;
  logic [15:0] op_rd_data;
  wire         eth_mdio;

  logic        bfm_drv_en = 1'b0;
  logic        bfm_drv_val = 1'b1;
  logic        bfm_present = 1'b0;
  logic        bfm_rd = 1'b0;
  logic [15:0] bfm_data = '0;
  int          bfm_idx = -1;
  logic [63:0] cap = '0;
  int          done_cnt = 0;
  int          mdio_viol = 0;
  int          oe_viol = 0;
  logic        mdc_prev = 1'b0, line_prev = 1'b1, oe_prev = 1'b0;

  int checks = 0;
  int failures = 0;

  pullup (eth_mdio);
  assign eth_mdio = bfm_drv_en ? bfm_drv_val : 1'bz;

  always #10 sys_clk = ~sys_clk;

  mdio_master #(.CLOCK_FREQ(50_000_000), .MDC_FREQ(1_000_000)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .op_exec     (op_exec),
    .op_rh_wl    (op_rh_wl),
    .op_phy_addr (op_phy_addr),
    .op_reg_addr (op_reg_addr),
    .op_wr_data  (op_wr_data),
    .busy        (busy),
    .op_done     (op_done),
    .op_rd_data  (op_rd_data),
    .op_rd_ack   (op_rd_ack),
    .eth_mdc     (eth_mdc),
    .eth_mdio    (eth_mdio)
  );

  // PHY model, frame capture and line monitor, all sampled mid-cycle.
  always @(negedge sys_clk) begin
    logic line, oe;
    line = eth_mdio;
    oe   = dut.mdio_oe_q;
    if (line !== line_prev && !(mdc_prev && !eth_mdc) && (oe || oe_prev)) mdio_viol++;
    if (!mdc_prev && eth_mdc && busy && bfm_idx >= 0 && bfm_idx <= 63) begin
      cap[63 - bfm_idx] = line;
      if (bfm_idx >= 46 && bfm_rd && oe) oe_viol++;
    end
    if (op_done) done_cnt++;
    if (mdc_prev && !eth_mdc) begin
      if (busy && bfm_idx < 63) bfm_idx++;
      if (busy && bfm_present && bfm_rd && bfm_idx == 47) begin
        bfm_drv_en = 1'b1; bfm_drv_val = 1'b0;
      end else if (busy && bfm_present && bfm_rd && bfm_idx >= 48 && bfm_idx <= 63) begin
        bfm_drv_en = 1'b1; bfm_drv_val = bfm_data[63 - bfm_idx];
      end else begin
        bfm_drv_en = 1'b0;
      end
    end
    if (!sys_rst_n) bfm_drv_en = 1'b0;
    mdc_prev  = eth_mdc;
    line_prev = line;
    oe_prev   = oe;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic start_op(input logic rd, input logic [4:0] phy, input logic [4:0] regad,
                          input logic [15:0] data);
    bfm_idx  = -1;
    done_cnt = 0;
    cap      = '0;
    bfm_rd   = rd;
    @(negedge sys_clk);
    op_rh_wl = rd; op_phy_addr = phy; op_reg_addr = regad; op_wr_data = data;
    op_exec  = 1'b1;
    @(negedge sys_clk);
    op_exec  = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat, output int busy_gap);
    lat = 1;
    busy_gap = 0;
    while (!op_done && lat < 5000) begin
      if (!busy) busy_gap++;
      @(negedge sys_clk);
      lat++;
    end
    check({tag, "_done"}, {63'd0, op_done}, 64'd1);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_idx(input int idx);
    int k = 0;
    while (bfm_idx != idx && k < 5000) begin
      @(negedge sys_clk);
      k++;
    end
    check("reach_bit", 64'(bfm_idx), 64'(idx));
  endtask

  initial begin
    int lat, gap, hi, lo, k;

    // Reset values
    #15;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, op_done}, 64'd0);
    check("rst_rd_data", {48'd0, op_rd_data}, 64'h0);
    check("rst_ack", {63'd0, op_rd_ack}, 64'd0);
    check("rst_mdc_oe", {62'd0, eth_mdc, dut.mdio_oe_q}, 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Divider: 25 cycles high, 25 low
    k = 0;
    while (!eth_mdc && k < 200) begin @(negedge sys_clk); k++; end
    hi = 0;
    while (eth_mdc && hi < 200) begin @(negedge sys_clk); hi++; end
    lo = 0;
    while (!eth_mdc && lo < 200) begin @(negedge sys_clk); lo++; end
    check("mdc_high", 64'(hi), 64'd25);
    check("mdc_low", 64'(lo), 64'd25);

    // Write
    bfm_present = 1'b1;
    start_op(1'b0, 5'h01, 5'h00, 16'h1140);
    check("wr_busy", {63'd0, busy}, 64'd1);
    wait_done("wr", lat, gap);
    check("wr_latency", {63'd0, (lat >= 3201 && lat <= 3250)}, 64'd1);
    check("wr_frame", cap, 64'hFFFFFFFF_50821140);
    check("wr_done_cnt", 64'(done_cnt), 64'd1);
    check("wr_rd_data", {48'd0, op_rd_data}, 64'h0);
    check("wr_rd_ack", {63'd0, op_rd_ack}, 64'd0);

    // Read with PHY present
    bfm_data = 16'h0141;
    start_op(1'b1, 5'h01, 5'h02, 16'h0000);
    wait_done("rd", lat, gap);
    check("rd_preamble", {32'd0, cap[63:32]}, 64'hFFFFFFFF);
    check("rd_header", {50'd0, cap[31:18]}, {50'd0, 14'b01_10_00001_00010});
    check("rd_data", {48'd0, op_rd_data}, 64'h0141);
    check("rd_ack", {63'd0, op_rd_ack}, 64'd1);
    check("rd_oe_released", 64'(oe_viol), 64'd0);

    // Read with no PHY
    bfm_present = 1'b0;
    start_op(1'b1, 5'h1F, 5'h02, 16'h0000);
    wait_done("nophy", lat, gap);
    check("nophy_data", {48'd0, op_rd_data}, 64'hFFFF);
    check("nophy_ack", {63'd0, op_rd_ack}, 64'd0);

    // op_exec while busy is ignored
    bfm_present = 1'b1;
    start_op(1'b0, 5'h03, 5'h04, 16'h1234);
    wait_idx(40);
    op_phy_addr = 5'h1F; op_reg_addr = 5'h1F; op_wr_data = 16'hAAAA; op_exec = 1'b1;
    @(negedge sys_clk);
    op_exec = 1'b0;
    wait_done("busy", lat, gap);
    check("busy_frame", cap, 64'hFFFFFFFF_51921234);
    check("busy_gap", 64'(gap), 64'd0);
    repeat (300) @(negedge sys_clk);
    check("busy_done_cnt", 64'(done_cnt), 64'd1);
    check("busy_idle", {63'd0, busy}, 64'd0);
    check("busy_rd_kept", {47'd0, op_rd_ack, op_rd_data}, {47'd0, 1'b0, 16'hFFFF});

    // Reset in the middle of a read
    bfm_data = 16'h5A5A;
    start_op(1'b1, 5'h01, 5'h03, 16'h0000);
    wait_idx(50);
    sys_rst_n  = 1'b0;
    bfm_drv_en = 1'b0;
    #1;
    check("mrst_oe", {63'd0, dut.mdio_oe_q}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_rd", {47'd0, op_rd_ack, op_rd_data}, 64'd0);
    done_cnt = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    check("mrst_no_done", 64'(done_cnt), 64'd0);
    check("mrst_line_up", {63'd0, eth_mdio}, 64'd1);

    bfm_data = 16'hBEEF;
    start_op(1'b1, 5'h01, 5'h03, 16'h0000);
    wait_done("post_rst", lat, gap);
    check("post_rst_data", {48'd0, op_rd_data}, 64'hBEEF);
    check("post_rst_ack", {63'd0, op_rd_ack}, 64'd1);

    check("mdio_on_fall", 64'(mdio_viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
